// File: rtl/qosc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qosc_pkg
// Description : Shared types and constants for the quadrature oscillator
//               configuration sequencer (state encoding, frame header,
//               frame geometry and power-on coefficient defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package qosc_pkg;

  // Controller states; explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_RX   = 2'd2
  } qosc_state_t;

  localparam logic [7:0] HEADER      = 8'hA5;
  localparam int         FRAME_BYTES = 10;
  localparam int         FRAME_BITS  = FRAME_BYTES * 8;

  // Power-on coefficient set, so the oscillator runs without host traffic
  localparam logic [15:0] RE_DEFAULT      = 16'h7d34;
  localparam logic [15:0] IM_DEFAULT      = 16'h1a9d;
  localparam logic [15:0] POWER_DEFAULT   = 16'h0400;
  localparam logic [15:0] ACCU_RE_DEFAULT = 16'h0020;
  localparam logic [15:0] ACCU_IM_DEFAULT = 16'h0000;

  // Frame image in wire order: byte 0 lands in the top byte
  localparam logic [FRAME_BITS-1:0] FRAME_DEFAULT = {RE_DEFAULT, IM_DEFAULT,
    POWER_DEFAULT, ACCU_RE_DEFAULT, ACCU_IM_DEFAULT};

endpackage
`default_nettype wire

// File: rtl/qosc_ctrl_shadow.sv
`default_nettype none
// ============================================================================
// Module      : qosc_ctrl_shadow
// Description : 80-bit byte-addressed shadow register. Byte 0 is the MSB of
//               the real coefficient. A reload overwrites the whole image and
//               takes priority over a byte write.
// Revision    : 1.0 - initial release
// ============================================================================
module qosc_ctrl_shadow
  import qosc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [3:0]            wr_idx,
  input  logic [7:0]            wr_byte,
  input  logic                  reload,
  input  logic [FRAME_BITS-1:0] reload_data,
  output logic [FRAME_BITS-1:0] data
);

  logic [FRAME_BITS-1:0] shadow_q;
  logic [FRAME_BITS-1:0] shadow_d;

  // Next shadow image: full reload, or a single addressed byte replaced
  always_comb begin
    shadow_d = shadow_q;
    if (reload) begin
      shadow_d = reload_data;
    end else if (wr_en) begin
      for (int i = 0; i < FRAME_BYTES; i++) begin
        if (wr_idx == 4'(i)) begin
          shadow_d[FRAME_BITS-1-8*i -: 8] = wr_byte;
        end
      end
    end
  end

  // Shadow storage, reset to the power-on frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= FRAME_DEFAULT;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign data = shadow_q;

endmodule
`default_nettype wire

// File: rtl/qosc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : qosc_ctrl
// Description : Configuration sequencer for the quadrature oscillator. Collects
//               a header + 10-byte frame into a shadow register, commits it
//               atomically, pulses load for LOAD_CYCLES, then runs.
//               Optional feature macro: QOSC_CTRL_DECIM_EN (decimated
//               sample_stb in RUN; otherwise sample_stb follows running).
// Revision    : 1.0 - initial release
// ============================================================================
module qosc_ctrl
  import qosc_pkg::*;
#(
  parameter int LOAD_CYCLES = 4,
  parameter int TIMEOUT     = 1023,
  parameter int DECIM       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_stb,
  input  logic [7:0]  wr_data,
  input  logic        abort,
  output logic [15:0] re_coeff,
  output logic [15:0] im_coeff,
  output logic [15:0] power,
  output logic [15:0] accu_re_init,
  output logic [15:0] accu_im_init,
  output logic        load,
  output logic        running,
  output logic        busy,
  output logic        err,
  output logic        sample_stb
);

  localparam int LCW = $clog2(LOAD_CYCLES + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  qosc_state_t           state_q, state_d;
  logic [LCW-1:0]        load_cnt_q, load_cnt_d;
  logic [3:0]            byte_idx_q, byte_idx_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  err_q, err_d;
  logic                  load_q, load_d;
  logic                  running_q, running_d;
  logic                  busy_q, busy_d;
  logic [FRAME_BITS-1:0] out_q, out_d;

  logic                  sh_wr;
  logic                  sh_reload;
  logic [FRAME_BITS-1:0] sh_data;

  qosc_ctrl_shadow u_shadow (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (sh_wr),
    .wr_idx      (byte_idx_q),
    .wr_byte     (wr_data),
    .reload      (sh_reload),
    .reload_data (out_q),
    .data        (sh_data)
  );

  // Sequencer next-state: frame reception, commit, timeout and abort handling
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    byte_idx_d = byte_idx_q;
    timer_d    = timer_q;
    err_d      = err_q;
    out_d      = out_q;
    sh_wr      = 1'b0;
    sh_reload  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        // Bytes arriving here are deliberately ignored
        if (load_cnt_q == LCW'(LOAD_CYCLES - 1)) begin
          state_d    = ST_RUN;
          load_cnt_d = '0;
        end else begin
          load_cnt_d = load_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (wr_stb) begin
          if (wr_data == HEADER) begin
            state_d    = ST_RX;
            byte_idx_d = '0;
            timer_d    = '0;
            err_d      = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RX: begin
        if (abort) begin
          state_d   = ST_RUN;
          sh_reload = 1'b1;
        end else if (wr_stb) begin
          sh_wr   = 1'b1;
          timer_d = '0;
          if (byte_idx_q == 4'(FRAME_BYTES - 1)) begin
            // Last byte bypasses the shadow so the commit includes it
            out_d      = {sh_data[FRAME_BITS-1:8], wr_data};
            state_d    = ST_LOAD;
            load_cnt_d = '0;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d     = 1'b1;
          sh_reload = 1'b1;
          state_d   = ST_RUN;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_LOAD;
        load_cnt_d = '0;
      end
    endcase
    load_d    = (state_d == ST_LOAD);
    running_d = (state_d == ST_RUN);
    busy_d    = (state_d == ST_RX);
  end

  // Sequencer state, status flags and committed coefficient registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      load_cnt_q <= '0;
      byte_idx_q <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      load_q     <= 1'b1;
      running_q  <= 1'b0;
      busy_q     <= 1'b0;
      out_q      <= FRAME_DEFAULT;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      byte_idx_q <= byte_idx_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      load_q     <= load_d;
      running_q  <= running_d;
      busy_q     <= busy_d;
      out_q      <= out_d;
    end
  end

`ifdef QOSC_CTRL_DECIM_EN
  localparam int DW = $clog2(DECIM);

  logic [DW-1:0] decim_cnt_q, decim_cnt_d;
  logic          sample_stb_q, sample_stb_d;

  // Decimation: counter restarts on RUN entry, pulse lands in RUN cycle DECIM
  always_comb begin
    decim_cnt_d  = '0;
    sample_stb_d = 1'b0;
    if (state_q == ST_RUN && state_d == ST_RUN) begin
      decim_cnt_d  = (decim_cnt_q == DW'(DECIM - 1)) ? '0 : decim_cnt_q + 1'b1;
      sample_stb_d = (decim_cnt_q == DW'(DECIM - 2));
    end
  end

  // Decimation counter and strobe register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decim_cnt_q  <= '0;
      sample_stb_q <= 1'b0;
    end else begin
      decim_cnt_q  <= decim_cnt_d;
      sample_stb_q <= sample_stb_d;
    end
  end

  assign sample_stb = sample_stb_q;
`else
  // Every RUN cycle carries a sample; the DECIM term is constant-true for any
  // legal configuration and keeps the parameter referenced in this build
  assign sample_stb = running_q && (DECIM >= 2);
`endif

  assign re_coeff     = out_q[79:64];
  assign im_coeff     = out_q[63:48];
  assign power        = out_q[47:32];
  assign accu_re_init = out_q[31:16];
  assign accu_im_init = out_q[15:0];
  assign load         = load_q;
  assign running      = running_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_qosc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_qosc_ctrl
// Description : Self-checking bench for qosc_ctrl. Expected commits are queued
//               by the stimulus; a monitor pops one on every load rising edge
//               and also checks the load pulse length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qosc_ctrl;

  localparam logic [79:0] DEF = {16'h7d34, 16'h1a9d, 16'h0400, 16'h0020, 16'h0000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_stb = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        abort = 1'b0;
  logic [15:0] re_coeff, im_coeff, power, accu_re_init, accu_im_init;
  logic        load, running, busy, err, sample_stb;

  int          tests = 0;
  int          fails = 0;
  logic [79:0] exp_q[$];
  logic [79:0] model_out;

  wire [79:0] dut_out = {re_coeff, im_coeff, power, accu_re_init, accu_im_init};

  qosc_ctrl #(.LOAD_CYCLES(4), .TIMEOUT(1023), .DECIM(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_stb       (wr_stb),
    .wr_data      (wr_data),
    .abort        (abort),
    .re_coeff     (re_coeff),
    .im_coeff     (im_coeff),
    .power        (power),
    .accu_re_init (accu_re_init),
    .accu_im_init (accu_im_init),
    .load         (load),
    .running      (running),
    .busy         (busy),
    .err          (err),
    .sample_stb   (sample_stb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All drive tasks run in the phase 1ns after a rising edge
  task automatic send_byte(input logic [7:0] b);
    wr_stb  = 1'b1;
    wr_data = b;
    @(posedge clk); #1;
    wr_stb  = 1'b0;
  endtask

  task automatic send_frame(input logic [79:0] f);
    exp_q.push_back(f);
    model_out = f;
    send_byte(8'hA5);
    for (int i = 0; i < 10; i++) send_byte(f[79-8*i -: 8]);
  endtask

  task automatic wait_running(input int budget);
    int n = 0;
    while (!running && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_running", {79'd0, running}, 80'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: one expected commit per load rising edge, pulse length 4
  initial begin
    logic prev = 1'b0;
    int   len  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
        len  = 0;
      end else begin
        if (load && !prev) begin
          len = 1;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL commit: unexpected commit %h", dut_out);
          end else begin
            check("commit", dut_out, exp_q.pop_front());
          end
        end else if (load) begin
          len++;
        end else if (prev) begin
          check("load_len", 80'(len), 80'd4);
          check("run_after_load", {79'd0, running}, 80'd1);
        end
        prev = load;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d pending", exp_q.size());
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    // 1: reset defaults, LOAD first, then RUN with no traffic
    model_out = DEF;
    exp_q.push_back(DEF);
    @(posedge clk); #2;
    check("rst_load", {79'd0, load}, 80'd1);
    check("rst_status", {77'd0, running, busy, err}, 80'd0);
    check("rst_outputs", dut_out, DEF);
    @(posedge clk); #1;
    rst = 1'b0;
    check("stb_in_load", {79'd0, sample_stb}, 80'd0);
    wait_running(20);
    idle(2);
    check("err_idle", {79'd0, err}, 80'd0);

    // 2: documented frame, then stray byte while loading is ignored
    send_frame({16'h4000, 16'h0000, 16'h0400, 16'h0010, 16'h0000});
    check("load_after_commit", {79'd0, load}, 80'd1);
    send_byte(8'h3C);
    wait_running(20);
    check("err_load_byte", {79'd0, err}, 80'd0);
`ifndef QOSC_CTRL_DECIM_EN
    check("stb_in_run", {79'd0, sample_stb}, 80'd1);
`endif

    // 3: stray byte sets err, header clears it
    send_byte(8'h3C);
    check("err_stray", {78'd0, err, running}, 80'd3);
    send_byte(8'hA5);
    check("hdr_clears_err", {78'd0, err, busy}, 80'd1);
    for (int i = 0; i < 10; i++) send_byte(8'h12 + 8'(i * 17));
    exp_q.push_back(80'h12233445566778899AAB);
    model_out = 80'h12233445566778899AAB;
    wait_running(20);

    // 4: timeout after 1023 idle cycles, then a clean frame from byte 0
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(8'h11 * 8'(i + 1));
    idle(1022);
    check("pre_timeout", {78'd0, busy, err}, 80'd2);
    idle(1);
    check("timeout", {78'd0, running, err}, 80'd3);
    check("timeout_outputs", dut_out, model_out);
    send_frame(80'hCAFE_BEEF_0123_4567_89AB);
    wait_running(20);
    check("err_after_frame", {79'd0, err}, 80'd0);

    // 5: abort with coincident strobe after 6 payload bytes
    send_byte(8'hA5);
    for (int i = 0; i < 6; i++) send_byte(8'h5A);
    abort = 1'b1; wr_stb = 1'b1; wr_data = 8'h77;
    @(posedge clk); #1;
    abort = 1'b0; wr_stb = 1'b0;
    check("abort_state", {77'd0, running, busy, err}, 80'd4);
    idle(3);
    check("abort_outputs", dut_out, model_out);
    send_frame(80'h0102_0304_0506_0708_090A);
    wait_running(20);

    // 6: async reset mid-frame
    send_byte(8'hA5);
    for (int i = 0; i < 3; i++) send_byte(8'hEE);
    exp_q.push_back(DEF);
    model_out = DEF;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_outputs", dut_out, DEF);
    check("mid_rst_status", {76'd0, load, running, busy, err}, 80'h8);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_running(20);
`ifdef QOSC_CTRL_DECIM_EN
    begin
      int n = 1;
      while (!sample_stb && n < 100) begin @(posedge clk); #1; n++; end
      check("decim_first", 80'(n), 80'd16);
      @(posedge clk); #1;
      n = 1;
      while (!sample_stb && n < 100) begin @(posedge clk); #1; n++; end
      check("decim_period", 80'(n), 80'd16);
    end
`else
    check("stb_eq_running", {78'd0, sample_stb, running}, 80'd3);
`endif
    idle(5);
    check("queue_drained", 80'(exp_q.size()), 80'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
